// File: rtl/input_interface.sv
// Memory-mapped input peripheral: synchronizes slide switches and push-buttons, debounces the
// buttons, latches press events as sticky write-1-to-clear flags and exposes everything through
// a four-word register map with a registered (1-cycle latency) read port.
// Optional feature: define KEY_IRQ_EN to add an interrupt mask register at word 3 and the
// registered interrupt output oIRQ.
module input_interface #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic [9:0]  iSW,
    input  logic [3:0]  iKEY,
    input  logic [1:0]  iAddr,
    input  logic        iRead,
    input  logic        iWrite,
    input  logic [31:0] iWData,
`ifdef KEY_IRQ_EN
    output logic        oIRQ,
`endif
    output logic [31:0] oRData
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Synchronizers: keys are kept in raw active-low form so their reset value means released.
    logic [9:0]             sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
    logic [3:0]             key_meta_q, key_meta_d, key_sync_q, key_sync_d;
    logic [3:0]             key_s;

    logic [3:0]             key_db_q, key_db_d;
    logic [3:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]             flag_q, flag_d;
    logic [3:0]             press;
    logic [3:0]             flag_clr;
    logic [31:0]            rdata_q, rdata_d;

`ifdef KEY_IRQ_EN
    logic [3:0]             mask_q, mask_d;
    logic                   irq_q, irq_d;
`endif

    // Upper write-data bits have no destination in this register map.
    logic unused_wdata;
    assign unused_wdata = ^iWData[31:4];

    // Two-flop synchronizer next-state.
    always_comb begin
        sw_meta_d  = iSW;
        sw_sync_d  = sw_meta_q;
        key_meta_d = iKEY;
        key_sync_d = key_meta_q;
    end

    // Per-key debounce: a change is accepted only after DEBOUNCE_CYCLES consecutive samples
    // disagree with the debounced value; any agreeing sample restarts the count.
    always_comb begin
        key_s    = ~key_sync_q;
        key_db_d = key_db_q;
        cnt_d    = cnt_q;
        for (int k = 0; k < 4; k++) begin
            if (key_s[k] == key_db_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == CntMax) begin
                key_db_d[k] = key_s[k];
                cnt_d[k]    = '0;
            end else begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
        end
    end

    // Sticky press flags with write-1-to-clear; a new press wins over a same-cycle clear.
    always_comb begin
        press    = key_db_d & ~key_db_q;
        flag_clr = (iWrite && (iAddr == 2'd2)) ? iWData[3:0] : 4'b0;
        flag_d   = (flag_q & ~flag_clr) | press;
    end

`ifdef KEY_IRQ_EN
    // Interrupt mask register and registered interrupt request.
    always_comb begin
        mask_d = (iWrite && (iAddr == 2'd3)) ? iWData[3:0] : mask_q;
        irq_d  = |(flag_q & mask_q);
    end

    assign oIRQ = irq_q;
`endif

    // Read mux samples pre-update state, so a same-cycle write is not visible to the read.
    always_comb begin
        rdata_d = rdata_q;
        if (iRead) begin
            unique case (iAddr)
                2'd0: rdata_d = {22'b0, sw_sync_q};
                2'd1: rdata_d = {28'b0, key_db_q};
                2'd2: rdata_d = {28'b0, flag_q};
`ifdef KEY_IRQ_EN
                2'd3: rdata_d = {28'b0, mask_q};
`else
                2'd3: rdata_d = 32'b0;
`endif
                default: rdata_d = 32'b0;
            endcase
        end
    end

    assign oRData = rdata_q;

    // State registers; key synchronizers reset to released so reset release is not a press.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            key_meta_q <= '1;
            key_sync_q <= '1;
            key_db_q   <= '0;
            cnt_q      <= '0;
            flag_q     <= '0;
            rdata_q    <= '0;
`ifdef KEY_IRQ_EN
            mask_q     <= '0;
            irq_q      <= 1'b0;
`endif
        end else begin
            sw_meta_q  <= sw_meta_d;
            sw_sync_q  <= sw_sync_d;
            key_meta_q <= key_meta_d;
            key_sync_q <= key_sync_d;
            key_db_q   <= key_db_d;
            cnt_q      <= cnt_d;
            flag_q     <= flag_d;
            rdata_q    <= rdata_d;
`ifdef KEY_IRQ_EN
            mask_q     <= mask_d;
            irq_q      <= irq_d;
`endif
        end
    end

endmodule

// File: tb/tb_input_interface.sv
// Self-checking bench for input_interface with a short debounce window.
// A reference model advances on every clock edge from the raw inputs and queues the expected
// read data; an independent monitor pops and compares one cycle after each read.
module tb_input_interface;

    localparam int unsigned D = 4;

    logic        iCLK;
    logic        iRST_n;
    logic [9:0]  iSW;
    logic [3:0]  iKEY;
    logic [1:0]  iAddr;
    logic        iRead;
    logic        iWrite;
    logic [31:0] iWData;
    logic [31:0] oRData;
`ifdef KEY_IRQ_EN
    logic        oIRQ;
`endif

    input_interface #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (3)
    ) dut (
        .iCLK  (iCLK),
        .iRST_n(iRST_n),
        .iSW   (iSW),
        .iKEY  (iKEY),
        .iAddr (iAddr),
        .iRead (iRead),
        .iWrite(iWrite),
        .iWData(iWData),
`ifdef KEY_IRQ_EN
        .oIRQ  (oIRQ),
`endif
        .oRData(oRData)
    );

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic        rd_pend = 1'b0;

    // Reference model state.
    logic [9:0]        m_sw0, m_sw1;   // switch value 1 and 2 edges ago
    logic [D:0][3:0]   m_hp;           // m_hp[i] = pressed pattern sampled i+1 edges ago
    logic [3:0]        m_db, m_flag, m_mask;
    logic              m_irq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Debounced key equals the synchronized samples once the last D of them all agree.
    function automatic logic [3:0] next_db(input logic [3:0] db, input logic [D:0][3:0] hp);
        logic [3:0] r;
        r = db;
        for (int k = 0; k < 4; k++) begin
            int ones;
            ones = 0;
            for (int i = 1; i <= D; i++) ones += int'(hp[i][k]);
            if (ones == int'(D)) r[k] = 1'b1;
            else if (ones == 0) r[k] = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [31:0] reg_model(input logic [1:0] a);
        case (a)
            2'd0: return {22'b0, m_sw1};
            2'd1: return {28'b0, m_db};
            2'd2: return {28'b0, m_flag};
`ifdef KEY_IRQ_EN
            default: return {28'b0, m_mask};
`else
            default: return 32'b0;
`endif
        endcase
    endfunction

    // Reference model, stepped on every active edge.
    initial begin
        logic [3:0] db_n, clr;
        forever begin
            @(posedge iCLK or negedge iRST_n);
            if (!iRST_n) begin
                m_sw0 = '0; m_sw1 = '0; m_hp = '0;
                m_db = '0; m_flag = '0; m_mask = '0; m_irq = 1'b0;
                exp_q.delete();
            end else begin
                if (iRead) exp_q.push_back(reg_model(iAddr));
                db_n   = next_db(m_db, m_hp);
                clr    = (iWrite && iAddr == 2'd2) ? iWData[3:0] : 4'b0;
                m_irq  = |(m_flag & m_mask);
                m_flag = (m_flag & ~clr) | (db_n & ~m_db);
`ifdef KEY_IRQ_EN
                if (iWrite && iAddr == 2'd3) m_mask = iWData[3:0];
`endif
                m_db  = db_n;
                m_sw1 = m_sw0;
                m_sw0 = iSW;
                m_hp  = {m_hp[D-1:0], ~iKEY};
            end
        end
    end

    // Read tracker: marks that oRData must be checked after this edge.
    initial begin
        forever begin
            @(posedge iCLK or negedge iRST_n);
            rd_pend = iRST_n && iRead;
        end
    end

    // Monitor: compares away from the active edge.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge iCLK);
            if (!iRST_n) begin
                check("reset_rdata", oRData, 32'h0);
`ifdef KEY_IRQ_EN
                check("reset_irq", {31'b0, oIRQ}, 32'h0);
`endif
            end else begin
                if (rd_pend) begin
                    if (exp_q.size() == 0) begin
                        check("read_no_expect", 32'h1, 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        check("read_data", oRData, e);
                    end
                end
`ifdef KEY_IRQ_EN
                check("irq", {31'b0, oIRQ}, {31'b0, m_irq});
`endif
            end
        end
    end

    task automatic tick();
        @(negedge iCLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic op(input logic rd, input logic wr, input logic [1:0] a, input logic [31:0] d);
        iRead  = rd;
        iWrite = wr;
        iAddr  = a;
        iWData = d;
        tick();
        iRead  = 1'b0;
        iWrite = 1'b0;
    endtask

    initial begin
        int r;
        int idx;
        iRST_n = 1'b0; iKEY = 4'hF; iSW = 10'h2A5;
        iAddr = '0; iRead = 1'b0; iWrite = 1'b0; iWData = '0;
        idle(3);
        iRST_n = 1'b1;
        idle(2);
        op(1, 0, 2'd0, 0);
        op(1, 0, 2'd1, 0);
        op(1, 0, 2'd2, 0);

        // Clean press of KEY1.
        iKEY = 4'hD;
        idle(8);
        op(1, 0, 2'd1, 0);
        op(1, 0, 2'd2, 0);

        // Bouncing KEY0, then a held press.
        iKEY[0] = 1'b0; idle(3);
        iKEY[0] = 1'b1; idle(1);
        iKEY[0] = 1'b0; idle(3);
        iKEY[0] = 1'b1; idle(6);
        op(1, 0, 2'd1, 0);
        op(1, 0, 2'd2, 0);
        iKEY[0] = 1'b0; idle(8);
        op(1, 0, 2'd2, 0);

        // Flags to 4'hB, W1C, then clear colliding with a fresh KEY1 press.
        iKEY[3] = 1'b0; idle(8);
        iKEY = 4'hF; idle(8);
        op(1, 1, 2'd2, 32'h9);
        op(1, 0, 2'd2, 0);
        iKEY[1] = 1'b0;
        idle(5);
        op(0, 1, 2'd2, 32'h2);
        op(1, 0, 2'd2, 0);
        op(1, 0, 2'd1, 0);

        // Reset two cycles into a KEY3 press.
        iKEY = 4'hF; idle(8);
        iKEY[3] = 1'b0; idle(2);
        iRST_n = 1'b0; idle(2);
        iRST_n = 1'b1;
        op(1, 0, 2'd2, 0);
        op(1, 0, 2'd1, 0);
        idle(6);
        op(1, 0, 2'd2, 0);
        op(1, 0, 2'd1, 0);

`ifdef KEY_IRQ_EN
        // Masked interrupt path.
        iKEY = 4'hF; idle(8);
        op(0, 1, 2'd2, 32'hF);
        op(1, 1, 2'd3, 32'h4);
        op(1, 0, 2'd3, 0);
        iKEY[0] = 1'b0; idle(8);
        iKEY[2] = 1'b0; idle(8);
        op(0, 1, 2'd2, 32'h4);
        idle(3);
        op(1, 0, 2'd2, 0);
`endif

        // Randomized traffic.
        for (int it = 0; it < 1500; it++) begin
            if ($urandom_range(0, 399) == 0) begin
                iRST_n = 1'b0;
                tick();
                iRST_n = 1'b1;
            end
            if ($urandom_range(0, 19) == 0) iSW = 10'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                idx = $urandom_range(0, 3);
                iKEY[idx] = ~iKEY[idx];
            end
            r = $urandom_range(0, 9);
            if (r <= 3) op(1, 0, 2'($urandom), 0);
            else if (r == 4) op(0, 1, 2'($urandom), $urandom);
            else if (r == 5) op(1, 1, 2'($urandom), $urandom);
            else tick();
        end

        idle(3);
        check("queue_drain", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
